// File: rtl/vga_timing_rx_if.sv
// vga_timing_rx_if: VGA timing sink bus; master is the transmitter/bench side, slave is the receiver
interface vga_timing_rx_if;
  logic       clk_en;
  logic       hsync_in;
  logic       vsync_in;
  logic       active_in;
  logic       de_out;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       frame_start;
  logic       locked;
  logic       err_frame;
  logic [9:0] meas_h_total;
  logic [9:0] meas_v_total;
  logic [7:0] err_count;
  modport master (
    output clk_en, hsync_in, vsync_in, active_in,
    input  de_out, hpos, vpos, frame_start, locked, err_frame, meas_h_total, meas_v_total, err_count
  );
  modport slave (
    input  clk_en, hsync_in, vsync_in, active_in,
    output de_out, hpos, vpos, frame_start, locked, err_frame, meas_h_total, meas_v_total, err_count
  );
endinterface

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: VGA timing receiver with position recovery, line/frame measurement and lock FSM; VGA_RX_ERR_COUNT_EN enables err_count
module vga_timing_rx #(
  parameter int H_ACTIVE        = 8,
  parameter int H_TOTAL         = 16,
  parameter int V_ACTIVE        = 6,
  parameter int V_TOTAL         = 10,
  parameter bit SYNC_ACTIVE_LOW = 1'b0,
  parameter int LOCK_FRAMES     = 2
) (
  input logic           clk,
  input logic           rst,
  vga_timing_rx_if.slave bus
);
  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;
  localparam logic [9:0] CMAX = 10'd1023;
  localparam logic [9:0] HA   = 10'(H_ACTIVE);
  localparam logic [9:0] HT   = 10'(H_TOTAL);
  localparam logic [9:0] VA   = 10'(V_ACTIVE);
  localparam logic [9:0] VT   = 10'(V_TOTAL);
  localparam logic [9:0] V_TO = 10'(V_TOTAL + 1);
  localparam logic [3:0] LF   = 4'(LOCK_FRAMES);
  logic       hs, vs, act, hs_prev, vs_prev, act_prev;
  logic       hs_edge, vs_edge, rise, fall, run_bad, ln_bad;
  logic       line_bad, frame_bad, first_pend, frame_ok, timeout, err_n;
  logic       de_r, fs_r, err_r;
  logic [1:0] state, state_n;
  logic [3:0] match, match_n;
  logic [9:0] h_cnt, h_len, de_run, v_cnt, v_next, a_cnt, hpos_r, vpos_r, meas_h, meas_v;
  function automatic logic [9:0] inc(input logic [9:0] v);
    return v == CMAX ? v : v + 10'd1;
  endfunction
  assign hs      = bus.hsync_in ^ SYNC_ACTIVE_LOW;
  assign vs      = bus.vsync_in ^ SYNC_ACTIVE_LOW;
  assign act     = bus.active_in;
  assign hs_edge = hs && !hs_prev;
  assign vs_edge = vs && !vs_prev;
  assign rise    = act && !act_prev;
  assign fall    = !act && act_prev;
  assign h_len   = inc(h_cnt);
  assign run_bad = fall && de_run != HA;
  assign ln_bad  = hs_edge && h_len != HT;
  // an hs edge coincident with the vs edge still belongs to the ending frame
  assign v_next  = (hs_edge && v_cnt != V_TO) ? v_cnt + 10'd1 : v_cnt;
  assign timeout = hs_edge && !vs_edge && v_cnt == VT;
  assign frame_ok = !frame_bad && !run_bad && !line_bad && !ln_bad && v_next == VT && a_cnt == VA;
  always_comb begin
    state_n = state;
    match_n = match;
    err_n   = 1'b0;
    if (timeout) begin
      state_n = S_SEARCH;
      match_n = '0;
      err_n   = 1'b1;
    end else if (vs_edge) begin
      match_n = (state == S_MEASURE && frame_ok) ? match + 4'd1 : '0;
      err_n   = state != S_SEARCH && !frame_ok;
      state_n = (state == S_SEARCH || !frame_ok) ? S_MEASURE :
                (state == S_LOCKED || match_n >= LF) ? S_LOCKED : S_MEASURE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      act_prev   <= 1'b0;
      h_cnt      <= '0;
      meas_h     <= '0;
      de_run     <= '0;
      frame_bad  <= 1'b0;
      line_bad   <= 1'b0;
      v_cnt      <= '0;
      meas_v     <= '0;
      a_cnt      <= '0;
      de_r       <= 1'b0;
      hpos_r     <= '0;
      vpos_r     <= '0;
      first_pend <= 1'b0;
      state      <= S_SEARCH;
      match      <= '0;
      fs_r       <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      fs_r  <= bus.clk_en && vs_edge;
      err_r <= bus.clk_en && err_n;
      if (bus.clk_en) begin
        hs_prev    <= hs;
        vs_prev    <= vs;
        act_prev   <= act;
        h_cnt      <= hs_edge ? '0 : h_len;
        meas_h     <= hs_edge ? h_len : meas_h;
        de_run     <= fall ? '0 : act ? inc(de_run) : de_run;
        frame_bad  <= !vs_edge && (frame_bad || run_bad);
        line_bad   <= !vs_edge && (line_bad || ln_bad);
        v_cnt      <= vs_edge ? '0 : v_next;
        meas_v     <= vs_edge ? v_next : meas_v;
        a_cnt      <= vs_edge ? {9'd0, rise} : rise ? inc(a_cnt) : a_cnt;
        de_r       <= act;
        hpos_r     <= rise ? '0 : act ? inc(hpos_r) : hpos_r;
        vpos_r     <= rise ? ((first_pend || vs_edge) ? '0 : inc(vpos_r)) : vpos_r;
        first_pend <= (first_pend || vs_edge) && !rise;
        state      <= state_n;
        match      <= match_n;
      end
    end
  assign bus.de_out       = de_r;
  assign bus.hpos         = hpos_r;
  assign bus.vpos         = vpos_r;
  assign bus.frame_start  = fs_r;
  assign bus.locked       = state == S_LOCKED;
  assign bus.err_frame    = err_r;
  assign bus.meas_h_total = meas_h;
  assign bus.meas_v_total = meas_v;
`ifdef VGA_RX_ERR_COUNT_EN
  logic [7:0] err_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_cnt <= '0;
    else if (bus.clk_en && err_n && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
  assign bus.err_count = err_cnt;
`else
  assign bus.err_count = 8'd0;
`endif
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: scoreboard bench driving a 16x10 VGA raster into vga_timing_rx
module tb_vga_timing_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  vga_timing_rx_if bus();
  vga_timing_rx dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic fs, err, lk; logic [9:0] mh, mv; logic [7:0] ec;} ev_t;
  typedef struct {logic [9:0] h, v;} px_t;
`ifdef VGA_RX_ERR_COUNT_EN
  localparam bit ECE = 1'b1;
`else
  localparam bit ECE = 1'b0;
`endif
  ev_t evq[$];
  px_t pxq[$];
  ev_t e;
  px_t p;
  int total = 0, bad = 0, de_cnt = 0, nerr = 0;
  bit half = 0, px_en = 0, en_q = 0, full = 0;
  logic [49:0] cur, snap;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_de"}, bus.de_out, 0);
    chk({tag, "_hpos"}, bus.hpos, 0);
    chk({tag, "_vpos"}, bus.vpos, 0);
    chk({tag, "_fs"}, bus.frame_start, 0);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_err"}, bus.err_frame, 0);
    chk({tag, "_mh"}, bus.meas_h_total, 0);
    chk({tag, "_mv"}, bus.meas_v_total, 0);
    chk({tag, "_ec"}, bus.err_count, 0);
  endtask
  task automatic tk(input int y, input int x, input bit novs);
    bus.clk_en    = 1'b1;
    bus.active_in = y < 6 && x < 8;
    bus.hsync_in  = x == 10 || x == 11;
    bus.vsync_in  = !novs && (y == 7 || y == 8);
    if (px_en && y < 6 && x < 8) pxq.push_back('{h: 10'(x), v: 10'(y)});
    @(posedge clk); #1;
    if (half) begin
      bus.clk_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask
  task automatic line(input int y, input int len, input bit novs);
    for (int x = 0; x < len; x++) tk(y, x, novs);
  endtask
  task automatic frame(input int short_y, input bit novs);
    line(7, 16, novs);
    line(8, 16, novs);
    line(9, 16, novs);
    for (int y = 0; y < 7; y++) line(y, y == short_y ? 15 : 16, 1'b0);
  endtask
  task automatic ev(input bit fs, input bit err, input bit lk, input int mv);
    evq.push_back('{fs: fs, err: err, lk: lk, mh: 10'd16, mv: 10'(mv), ec: ECE ? 8'(nerr) : 8'd0});
  endtask
  always @(posedge clk) en_q <= bus.clk_en;
  always @(negedge clk) begin
    cur = {bus.de_out, bus.hpos, bus.vpos, bus.locked, bus.meas_h_total, bus.meas_v_total, bus.err_count};
    if (!rst) begin
      if (en_q) begin
        if (bus.de_out) de_cnt++;
        if (bus.de_out && px_en) begin
          if (pxq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pixel_extra got=hpos %0d vpos %0d want=no pixel", bus.hpos, bus.vpos);
          end else begin
            p = pxq.pop_front();
            chk("hpos", bus.hpos, p.h);
            chk("vpos", bus.vpos, p.v);
          end
        end
        if (bus.frame_start || bus.err_frame) begin
          if (evq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL event_extra got=fs %0b err %0b want=no event", bus.frame_start, bus.err_frame);
          end else begin
            e = evq.pop_front();
            chk("frame_start", bus.frame_start, e.fs);
            chk("err_frame", bus.err_frame, e.err);
            chk("locked", bus.locked, e.lk);
            chk("meas_h_total", bus.meas_h_total, e.mh);
            chk("meas_v_total", bus.meas_v_total, e.mv);
            chk("err_count", bus.err_count, e.ec);
          end
          if (bus.frame_start) begin
            if (full) chk("de_per_frame", de_cnt, 48);
            full = px_en;
            de_cnt = 0;
          end
        end
        if (!px_en) full = 0;
      end else begin
        chk("pulse_idle", {bus.frame_start, bus.err_frame}, 0);
        chk("hold_idle", cur, snap);
      end
    end
    snap = cur;
  end
  initial begin
    bus.clk_en    = 1'b0;
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;
    bus.active_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int y = 0; y < 4; y++) line(y, 16, 1'b0);
    for (int x = 0; x < 9; x++) tk(4, x, 1'b0);
    chk("meas_h_pre_rst", bus.meas_h_total, 16);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    for (int x = 9; x < 13; x++) tk(4, x, 1'b0);
    chk_zero("rst_hold");
    rst = 1'b0;
    for (int x = 13; x < 16; x++) tk(4, x, 1'b0);
    line(5, 16, 1'b0);
    line(6, 16, 1'b0);
    px_en = 1;
    ev(1, 0, 0, 2);  frame(-1, 1'b0);
    ev(1, 0, 0, 10); frame(-1, 1'b0);
    ev(1, 0, 1, 10); frame(-1, 1'b0);
    half = 1;
    ev(1, 0, 1, 10); frame(-1, 1'b0);
    ev(1, 0, 1, 10); frame(-1, 1'b0);
    half = 0;
    ev(1, 0, 1, 10); frame(2, 1'b0);
    nerr++;
    ev(1, 1, 0, 10); frame(-1, 1'b0);
    ev(1, 0, 0, 10); frame(-1, 1'b0);
    ev(1, 0, 1, 10); frame(-1, 1'b0);
    px_en = 0;
    nerr++;
    ev(0, 1, 0, 10); frame(-1, 1'b1);
    px_en = 1;
    ev(1, 0, 0, 11); frame(-1, 1'b0);
    ev(1, 0, 0, 10); frame(-1, 1'b0);
    ev(1, 0, 1, 10); frame(-1, 1'b0);
    ev(1, 0, 1, 10); line(7, 16, 1'b0);
    @(negedge clk); #1;
    chk("events_left", evq.size(), 0);
    chk("pixels_left", pxq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receiving end of the VGA timing interface driven by the `vga` generator; sits on the sink side of a video link (capture, overlay or loopback checker).
- Samples hsync, vsync and active on the pixel-rate clock enable.
- Recovers per-pixel hpos/vpos, measures line and frame totals, and runs a lock state machine against the expected mode parameters.

Parameters:
- H_ACTIVE, 8, expected active pixels per line.
- H_TOTAL, 16, expected clk_en ticks per line (active + front porch + sync + back porch).
- V_ACTIVE, 6, expected active lines per frame.
- V_TOTAL, 10, expected lines per frame.
- SYNC_ACTIVE_LOW, 0, 1 = hsync_in/vsync_in are asserted when low.
- LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..15).

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  pixel tick; all sampling and counting happens only when high.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- active_in  in  1  data-enable from transmitter.
- de_out  out  1  registered copy of active_in.
- hpos  out  10  recovered pixel index within active line.
- vpos  out  10  recovered active line index.
- frame_start  out  1  one-clk pulse on vsync leading edge.
- locked  out  1  timing matches parameters.
- err_frame  out  1  one-clk pulse when a frame fails check or times out.
- meas_h_total  out  10  last measured line length.
- meas_v_total  out  10  last measured frame length in lines.
- err_count  out  8  see optional feature.

Behaviour:
- Reset (async, rst=1): every output 0; all counters and previous-sample registers 0; FSM=SEARCH.
- Sampling:
  - Inputs are polarity-normalised (hs = hsync_in ^ SYNC_ACTIVE_LOW, same for vs).
  - Updates occur only on clk edges with clk_en=1; with clk_en=0 all state holds and pulses are 0.
  - Leading edge = normalised value 1 and previous sample 0.
  - Outputs are registered; latency is 1 clk_en tick from the input sample.
- Horizontal:
  - h_cnt increments each tick and saturates at 1023.
  - On hs edge: meas_h_total <= h_cnt+1, h_cnt <= 0, line_bad <= (h_cnt+1 != H_TOTAL).
  - de_run counts active_in=1 ticks; on active_in falling edge, run length != H_ACTIVE sets frame_bad.
- Position:
  - de_out = active_in.
  - hpos = 0 on the first active sample of a line, then +1 per active tick; holds while de_out=0.
  - vpos = 0 on the first active line after a vsync edge, +1 on the first active sample of each later line; saturates at 1023.
- Vertical:
  - v_cnt counts hs edges since the last vs edge. An hs edge coincident with a vs edge is counted in the ending frame.
  - On vs edge: meas_v_total <= v_cnt (including any coincident edge); frame_start=1.
  - frame_ok = !frame_bad && no line_bad in frame && v_cnt==V_TOTAL && active line count==V_ACTIVE.
  - Then clear frame_bad, v_cnt, active-line count.
- FSM:
  - SEARCH: ignore measurements; on vs edge -> MEASURE, match_cnt=0.
  - MEASURE: on vs edge, frame_ok increments match_cnt; at match_cnt==LOCK_FRAMES -> LOCKED, locked=1. Bad frame -> match_cnt=0, err_frame pulse, stay.
  - LOCKED: on vs edge with bad frame -> MEASURE, match_cnt=0, locked=0, err_frame pulse.
  - Any state: v_cnt reaching V_TOTAL+1 (missing vsync) -> SEARCH, locked=0, err_frame pulse, v_cnt held at V_TOTAL+1 until the next vs edge.
- rst asserted mid-frame: immediate return to reset values; the partial frame after release is discarded by SEARCH.

Optional Feature:
- Macro VGA_RX_ERR_COUNT_EN.
- Defined: err_count increments on every err_frame pulse, saturates at 255, cleared only by rst.
- Undefined: err_count tied to 0 and no counter logic is synthesised.

Test Plan:
- rst=1 mid-frame with syncs toggling -> all outputs 0 within the same cycle; after release, locked stays 0 until the required vs edges.
- Default-mode `vga` generator driving inputs, clk_en=1 -> locked rises at the 3rd vsync leading edge; meas_h_total=16, meas_v_total=10, one frame_start per frame.
- Same stimulus with clk_en high every 2nd clk -> identical tick-count results; no output changes on clk_en=0 cycles.
- Locked, then one line shortened to 15 ticks -> at the next vs edge locked=0 and err_frame for 1 clk; locked re-asserts 2 frames later; err_count=1 when VGA_RX_ERR_COUNT_EN is defined.
- Locked, then vsync held deasserted -> at the 11th hs edge: FSM=SEARCH, locked=0, err_frame pulse.
- Nominal frame -> first active pixel hpos=0 vpos=0; last active pixel hpos=7 vpos=5; de_out high exactly 48 ticks per frame.
